// File: rtl/ball_motion.sv
// ball_motion: ball position engine for RWPONG; turns clk_ball rising edges into moves,
// resolves wall/paddle bounces and miss scoring.
module ball_motion #(
   parameter int H_MAX      = 640,
   parameter int V_MAX      = 480,
   parameter int BALL_SIZE  = 8,
   parameter int PADDLE_L_X = 16,
   parameter int PADDLE_R_X = 616,
   parameter int PADDLE_W   = 8,
   parameter int PADDLE_H   = 64,
   parameter int HOLD_TICKS = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_ball,
   input  logic       serve,
   input  logic [9:0] paddle_l_y,
   input  logic [9:0] paddle_r_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       in_play,
   output logic       score_l,
   output logic       score_r
);
   localparam int CX = (H_MAX - BALL_SIZE) / 2;
   localparam int CY = (V_MAX - BALL_SIZE) / 2;
   localparam int XM = H_MAX - BALL_SIZE;
   localparam int YM = V_MAX - BALL_SIZE;
   localparam int HW = $clog2(HOLD_TICKS + 1);

   typedef enum logic [1:0] {IDLE, PLAY, SCORED} state_t;
   state_t state;

   logic sync1, sync2, prev, tick, dx, dy, serve_dir, ndx, ndy, ov_l, ov_r;
   logic [HW-1:0] hold;
   logic [10:0] bx, by;

   // 11-bit compares so ball_y+BALL_SIZE and P+PADDLE_H never wrap
   always_comb begin
      bx   = {1'b0, ball_x};
      by   = {1'b0, ball_y};
      tick = sync2 & ~prev;
      ov_l = (by + 11'(BALL_SIZE) > {1'b0, paddle_l_y}) && (by < {1'b0, paddle_l_y} + 11'(PADDLE_H));
      ov_r = (by + 11'(BALL_SIZE) > {1'b0, paddle_r_y}) && (by < {1'b0, paddle_r_y} + 11'(PADDLE_H));
      ndy  = (!dy && by == 11'd0) ? 1'b1 : (dy && by == 11'(YM)) ? 1'b0 : dy;
      ndx  = (!dx && bx == 11'(PADDLE_L_X + PADDLE_W) && ov_l) ? 1'b1 :
             (dx && bx + 11'(BALL_SIZE) == 11'(PADDLE_R_X) && ov_r) ? 1'b0 : dx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ball_x    <= 10'(CX);
         ball_y    <= 10'(CY);
         dx        <= 1'b1;
         dy        <= 1'b1;
         serve_dir <= 1'b1;
         in_play   <= 1'b0;
         score_l   <= 1'b0;
         score_r   <= 1'b0;
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         prev      <= 1'b0;
         hold      <= '0;
      end else begin
         sync1   <= clk_ball;
         sync2   <= sync1;
         prev    <= sync2;
         score_l <= 1'b0;
         score_r <= 1'b0;
         case (state)
            IDLE: if (serve) begin
               state     <= PLAY;
               in_play   <= 1'b1;
               dx        <= serve_dir;
               dy        <= 1'b1;
               serve_dir <= ~serve_dir;
            end
            PLAY: if (tick) begin
               if (!dx && bx == 11'd0) begin
                  score_r <= 1'b1;
                  state   <= SCORED;
                  in_play <= 1'b0;
               end else if (dx && bx == 11'(XM)) begin
                  score_l <= 1'b1;
                  state   <= SCORED;
                  in_play <= 1'b0;
               end else begin
                  dx     <= ndx;
                  dy     <= ndy;
                  ball_x <= ndx ? ball_x + 10'd1 : ball_x - 10'd1;
                  ball_y <= ndy ? ball_y + 10'd1 : ball_y - 10'd1;
               end
            end
            SCORED: if (tick) begin
               if (hold == HW'(HOLD_TICKS - 1)) begin
                  state  <= IDLE;
                  hold   <= '0;
                  ball_x <= 10'(CX);
                  ball_y <= 10'(CY);
               end else begin
                  hold <= hold + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/ball_motion.md
# ball_motion

Ball position engine for RWPONG, directly downstream of the ball-speed clock selector. It samples the selected `clk_ball` square wave in the 50 MHz domain and turns each rising edge into one movement tick. On each tick it advances the ball one pixel diagonally, resolves wall and paddle bounces, and detects misses. Its `ball_x`/`ball_y` outputs feed the VGA renderer, and its score pulses feed the score counters.

## Interface
- `H_MAX`, 640: playfield width in pixels.
- `V_MAX`, 480: playfield height in pixels.
- `BALL_SIZE`, 8: ball edge length in pixels (square ball).
- `PADDLE_L_X`, 16: x of the left paddle's left edge.
- `PADDLE_R_X`, 616: x of the right paddle's left edge.
- `PADDLE_W`, 8: paddle width.
- `PADDLE_H`, 64: paddle height.
- `HOLD_TICKS`, 64: ball ticks to hold after a score before recentering.

- `clk` in 1: 50 MHz system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `clk_ball` in 1: speed clock from the selector; treated as asynchronous data, never used as a clock.
- `serve` in 1: level, sampled each `clk`; starts play when the block is in IDLE.
- `paddle_l_y` in 10: top y of the left paddle.
- `paddle_r_y` in 10: top y of the right paddle.
- `ball_x` out 10: ball left x.
- `ball_y` out 10: ball top y.
- `in_play` out 1: high only in PLAY.
- `score_l` out 1: one-`clk` pulse; the left player scored (right side missed).
- `score_r` out 1: one-`clk` pulse; the right player scored (left side missed).

## Operation
- **Tick generation**
  - Two-flop synchronizer on `clk_ball`, then a previous-value flop.
  - `tick = sync2 & ~prev`.
- **All state updates** happen only on `clk` edges where `tick=1`, except `serve` handling and reset.
- **Direction registers**
  - `dx`: 1 = right, 0 = left.
  - `dy`: 1 = down, 0 = up.
  - `serve_dir` selects the next serve's `dx`.
- **Centre position**
  - CX = (H_MAX-BALL_SIZE)/2, CY = (V_MAX-BALL_SIZE)/2.
  - With defaults: 316, 236.
- **States**
  - **IDLE**: ball held at (CX,CY). When `serve`=1, go to PLAY with `dx<=serve_dir`, `dy<=1`, and toggle `serve_dir`. No tick is needed.
  - **PLAY**, on each tick, in this order:
    1. Miss check. If `dx=0` and `ball_x==0`: pulse `score_r` and go to SCORED. If `dx=1` and `ball_x==H_MAX-BALL_SIZE`: pulse `score_l` and go to SCORED. No movement on a miss tick.
    2. Vertical bounce. Flip `dy` to 1 if `dy=0` and `ball_y==0`. Flip `dy` to 0 if `dy=1` and `ball_y==V_MAX-BALL_SIZE`.
    3. Paddle bounce. Vertical overlap with a paddle at y P means `ball_y+BALL_SIZE > P` and `ball_y < P+PADDLE_H`. Left paddle: `dx=0`, `ball_x==PADDLE_L_X+PADDLE_W`, overlap with `paddle_l_y` → `dx<=1`. Right paddle: `dx=1`, `ball_x+BALL_SIZE==PADDLE_R_X`, overlap with `paddle_r_y` → `dx<=0`.
    4. Move. `ball_x±1` and `ball_y±1` using the post-flip directions.
  - **SCORED**: ball frozen. A hold counter increments per tick. On the HOLD_TICKS-th tick: go to IDLE, recenter, clear the counter. `serve` is ignored.
- **Simultaneous events**
  - Corner: both flips apply in the same tick.
  - Miss has priority over bounces.
  - `serve` in PLAY or SCORED has no effect.
- **Arithmetic**
  - Compares use 11-bit intermediates, so `ball_y+BALL_SIZE` and `P+PADDLE_H` cannot wrap.
  - Position never leaves [0, H_MAX-BALL_SIZE] × [0, V_MAX-BALL_SIZE].

## Timing
- **Reset values**
  - State IDLE; `ball_x`=CX, `ball_y`=CY.
  - `dx`=1, `dy`=1, `serve_dir`=1.
  - `in_play`=0, `score_l`=0, `score_r`=0.
  - Synchronizer flops, `prev` and hold counter = 0.
- **Reset mid-operation**: `rst` overrides everything on the same edge, including a coincident tick or `serve`.
- **Latency**
  - Position outputs change on the 3rd `clk` rising edge after `clk_ball` rises.
  - `clk_ball` must stay high and low for at least 2 `clk` cycles each; all selector outputs satisfy this.
- **Score pulses**: exactly one `clk` wide, asserted on the edge that enters SCORED.
- **Serve to play**: `in_play` rises one `clk` after `serve` is sampled in IDLE. The first move occurs on the next tick.
- **Outputs**: all registered; no combinational path from inputs to outputs.

## Test plan
- **Reset**: assert `rst` 2 cycles → `ball_x`=316, `ball_y`=236, `in_play`=0, no score pulses; toggle `clk_ball` with no serve → position unchanged.
- **Serve and first move**: pulse `serve`, then one `clk_ball` rise → `in_play`=1 next cycle; 3 `clk` edges after the rise, `ball_x`=317, `ball_y`=237.
- **Bottom bounce**: `paddle_r_y`=400. Tick 236 → (552,472). Tick 237 → (553,471).
- **Right paddle hit**: continue from the previous scenario. Tick 292 → (608,416). Tick 293 → (607,415), `dx`=0.
- **Miss and hold**: `paddle_r_y`=0. Tick 316 → (632,392). Tick 317 → `score_l` pulses 1 cycle, `in_play`=0, position frozen. 64 more ticks → IDLE at (316,236). The next serve goes left (`ball_x`=315 after first tick).
- **Reset mid-play and ignored serve**: toggle `serve` during PLAY → direction unchanged. Assert `rst` on a tick edge → all reset values restored on that edge.
